// File: rtl/alu_result_tx_if.sv
// Handshake and serial-line bundle for the ALU result transmitter.
// The master drives result words in; the slave reports line and frame status.
interface alu_result_tx_if;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [7:0] frame_count;

    modport master (
        output data_in,
        output valid,
        input  ready,
        input  tx,
        input  busy,
        input  frame_count
    );

    modport slave (
        input  data_in,
        input  valid,
        output ready,
        output tx,
        output busy,
        output frame_count
    );
endinterface

// File: rtl/alu_result_tx.sv
// Serial transmitter for ALU results: start, 8 data bits LSB-first, optional
// even parity, stop. Keeps a wrapping count of completed frames.
module alu_result_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    alu_result_tx_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic        tx_q;
    logic [7:0]  count_q;
    logic        bit_done;

    assign bit_done = (timer_q == BIT_LAST);

    // Shift register and parity are pure data: loaded on acceptance, never reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid) begin
                        shift_q  <= bus.data_in;
                        parity_q <= ^bus.data_in;
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        timer_q  <= '0;
                        bit_q    <= '0;
                    end
                end
                default: begin
                    if (!bit_done) begin
                        timer_q <= timer_q + 16'd1;
                    end else begin
                        timer_q <= '0;
                        case (state_q)
                            START: begin
                                state_q <= DATA;
                                tx_q    <= shift_q[0];
                            end
                            DATA: begin
                                if (bit_q == 3'd7) begin
                                    if (PARITY_EN) begin
                                        state_q <= PARITY;
                                        tx_q    <= parity_q;
                                    end else begin
                                        state_q <= STOP;
                                        tx_q    <= 1'b1;
                                    end
                                end else begin
                                    bit_q   <= bit_q + 3'd1;
                                    shift_q <= {1'b0, shift_q[7:1]};
                                    tx_q    <= shift_q[1];
                                end
                            end
                            PARITY: begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                            STOP: begin
                                state_q <= IDLE;
                                tx_q    <= 1'b1;
                                count_q <= count_q + 8'd1;
                            end
                            default: begin
                                state_q <= IDLE;
                                tx_q    <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.ready       = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.tx          = tx_q;
    assign bus.frame_count = count_q;
endmodule
